router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-flow controller for the 1x3 router. Sits upstream of the three output FIFOs and the header/parity register.
- Decodes the destination address from the header byte and sequences header, payload and parity loading.
- Generates lfd_state, which marks the header word as it is written into a FIFO.
- Stalls the source through busy while the destination FIFO is full or not yet drained.

Parameters:
- None. Destination count is fixed at 3; address 2'b11 is invalid.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pkt_valid  input  1  source byte valid; deasserts after the last payload byte
- data_in  input  2  low bits of the source byte; destination address during header
- fifo_full  input  1  full flag of the currently selected FIFO
- fifo_empty_0/1/2  input  1 each  empty flags of FIFOs 0..2
- soft_reset_0/1/2  input  1 each  per-FIFO timeout soft resets
- parity_done  input  1  register block has captured the parity byte
- low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full
- detect_add  output  1  in DECODE_ADDRESS
- lfd_state  output  1  in LOAD_FIRST_DATA
- ld_state  output  1  in LOAD_DATA
- laf_state  output  1  in LOAD_AFTER_FULL
- full_state  output  1  in FIFO_FULL_STATE
- write_enb_reg  output  1  FIFO write strobe (LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL)
- rst_int_reg  output  1  in CHECK_PARITY_ERROR; clears the internal parity register
- busy  output  1  source must hold; high in every state except DECODE_ADDRESS and LOAD_DATA
- dest_addr  output  2  latched destination address

Behaviour:
- Moore machine. All outputs except dest_addr decode combinationally from the state register. No output depends directly on inputs.
- Reset: state=DECODE_ADDRESS and dest_addr=0. Resulting outputs: detect_add=1, all other strobes=0, busy=0. Reset mid-packet aborts the packet immediately.
- dest_addr loads data_in when state=DECODE_ADDRESS, pkt_valid=1 and data_in!=3. It holds otherwise.
- For transitions below, fifo_empty_sel means fifo_empty_<dest_addr>. In DECODE_ADDRESS it is evaluated on the live data_in.
- Soft reset has priority over all transitions except reset. If soft_reset_k=1 and k==dest_addr, next state is DECODE_ADDRESS from any state. A soft_reset on a non-selected port is ignored.
- DECODE_ADDRESS:
  - pkt_valid and data_in==k (k<3) and fifo_empty_k go to LOAD_FIRST_DATA.
  - pkt_valid and data_in==k and !fifo_empty_k go to WAIT_TILL_EMPTY.
  - Otherwise stay. data_in==3 is dropped: stay, no latch.
- WAIT_TILL_EMPTY: fifo_empty_sel goes to LOAD_FIRST_DATA; otherwise stay.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally. Exactly one cycle.
- LOAD_DATA:
  - fifo_full goes to FIFO_FULL_STATE.
  - Else !pkt_valid goes to LOAD_PARITY.
  - Else stay.
  - fifo_full has priority.
- FIFO_FULL_STATE: !fifo_full goes to LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - parity_done goes to DECODE_ADDRESS.
  - Else low_pkt_valid goes to LOAD_PARITY.
  - Else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: fifo_full goes to FIFO_FULL_STATE; otherwise go to DECODE_ADDRESS.
- Encoding: 8 states, 3-bit register. Unreachable codes recover to DECODE_ADDRESS on the next clock.
- Header latency: header byte presented with pkt_valid in DECODE_ADDRESS → lfd_state=1 in the next cycle.
- Back-to-back packets: a new header may be accepted in the first DECODE_ADDRESS cycle after CHECK_PARITY_ERROR.

Test Plan:
- Reset held 2 cycles, then released → detect_add=1, busy=0, dest_addr=0, all other strobes=0.
- Header data_in=2'b01, pkt_valid=1, fifo_empty_1=1; then 3 payload cycles; then pkt_valid=0 → state sequence DEC, LFD, LD, LD, LD, LP, CPE, DEC. dest_addr=1. write_enb_reg=1 for exactly 4 cycles (3 payload + parity). rst_int_reg=1 for 1 cycle.
- Header to port 2 with fifo_empty_2=0 for 5 cycles, then 1 → WAIT_TILL_EMPTY for 5 cycles with busy=1 and lfd_state=0. lfd_state=1 in the cycle after fifo_empty_2 rises.
- In LOAD_DATA, fifo_full=1 for 3 cycles → full_state=1 for 3 cycles with busy=1. Then LOAD_AFTER_FULL, and:
  - low_pkt_valid=0 → returns to LOAD_DATA.
  - Repeat with low_pkt_valid=1 → goes to LOAD_PARITY.
  - Repeat with parity_done=1 → goes to DECODE_ADDRESS.
- Mid-packet on port 0:
  - soft_reset_1 pulse → no effect.
  - soft_reset_0 pulse during FIFO_FULL_STATE → DECODE_ADDRESS next cycle, detect_add=1.
- Header data_in=2'b11 with pkt_valid=1 → stays in DECODE_ADDRESS, dest_addr unchanged. Assert reset during LOAD_DATA → DECODE_ADDRESS next cycle.

Source files
------------

// File: rtl/router_fsm.sv
// Packet-flow controller for the 1x3 router: decodes the destination from the header,
// sequences header/payload/parity loading and stalls the source while the FIFO is busy.
module router_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic [1:0] dest_addr
);

    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = ADDR_W'(3);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic              empty_sel;
    logic              soft_sel;
    logic              hdr_ok;

    // While decoding, the live header picks the FIFO; afterwards the latched address does.
    always_comb begin
        sel_addr = (state == DECODE_ADDRESS) ? data_in : dest_addr;
        hdr_ok   = pkt_valid && (data_in != ADDR_INVALID);
        case (sel_addr)
            2'd0:    empty_sel = fifo_empty_0;
            2'd1:    empty_sel = fifo_empty_1;
            2'd2:    empty_sel = fifo_empty_2;
            default: empty_sel = 1'b0;
        endcase
        case (dest_addr)
            2'd0:    soft_sel = soft_reset_0;
            2'd1:    soft_sel = soft_reset_1;
            2'd2:    soft_sel = soft_reset_2;
            default: soft_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DECODE_ADDRESS;
            dest_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && hdr_ok) begin
                dest_addr <= data_in;
            end
        end
    end

    // Next-state and Moore output decode; a soft reset of the selected FIFO wins.
    always_comb begin
        state_nxt     = state;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;

        case (state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
                if (hdr_ok) state_nxt = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) state_nxt = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                state_nxt = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
                if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                if (parity_done)        state_nxt = DECODE_ADDRESS;
                else if (low_pkt_valid) state_nxt = LOAD_PARITY;
                else                    state_nxt = LOAD_DATA;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                state_nxt     = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                state_nxt   = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
                state_nxt = DECODE_ADDRESS;
            end
        endcase

        if (soft_sel) state_nxt = DECODE_ADDRESS;
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed scenarios plus a randomized run
// compared against a phase-level reference model of the packet flow.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic [2:0] empty, sreset;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [1:0] dest_addr;
    logic [9:0] obs;

    int checks = 0;
    int fails  = 0;

    // Packet phases of the reference model (independent of the RTL encoding).
    localparam int P_DEC = 10, P_LFD = 11, P_LD = 12, P_LAF = 13,
                   P_FULL = 14, P_LP = 15, P_CPE = 16, P_WTE = 17;

    int         m_ph;
    logic [1:0] m_addr;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
        .soft_reset_0(sreset[0]), .soft_reset_1(sreset[1]), .soft_reset_2(sreset[2]),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy), .dest_addr(dest_addr)
    );

    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, busy, dest_addr};

    // Expected outputs {detect,lfd,ld,laf,full,wen,rst_int,busy,addr} for a phase.
    function automatic logic [9:0] exp_of(input int ph, input logic [1:0] addr);
        logic [7:0] f;
        case (ph)
            P_DEC:   f = 8'b1000_0000;
            P_LFD:   f = 8'b0100_0001;
            P_LD:    f = 8'b0010_0100;
            P_LAF:   f = 8'b0001_0101;
            P_FULL:  f = 8'b0000_1001;
            P_LP:    f = 8'b0000_0101;
            P_CPE:   f = 8'b0000_0011;
            P_WTE:   f = 8'b0000_0001;
            default: f = 8'hxx;
        endcase
        return {f, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance the reference model by one clock using the inputs currently applied.
    task automatic model_step();
        int         nph;
        logic [1:0] naddr;
        nph   = m_ph;
        naddr = m_addr;
        if (reset) begin
            nph   = P_DEC;
            naddr = 2'd0;
        end else begin
            if (m_ph == P_DEC && pkt_valid && data_in != 2'd3) naddr = data_in;
            if (sreset[m_addr]) nph = P_DEC;
            else if (m_ph == P_DEC) begin
                if (pkt_valid && data_in != 2'd3) nph = empty[data_in] ? P_LFD : P_WTE;
            end
            else if (m_ph == P_WTE)  nph = empty[m_addr] ? P_LFD : P_WTE;
            else if (m_ph == P_LFD)  nph = P_LD;
            else if (m_ph == P_LD)   nph = fifo_full ? P_FULL : (!pkt_valid ? P_LP : P_LD);
            else if (m_ph == P_FULL) nph = fifo_full ? P_FULL : P_LAF;
            else if (m_ph == P_LAF)  nph = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
            else if (m_ph == P_LP)   nph = P_CPE;
            else if (m_ph == P_CPE)  nph = fifo_full ? P_FULL : P_DEC;
        end
        m_ph   = nph;
        m_addr = naddr;
    endtask

    task automatic test_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        empty = 3'b111; sreset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (obs !== exp_of(P_DEC, 2'd0)) begin
            fails++; $display("FAIL reset_state: got %b expected %b", obs, exp_of(P_DEC, 2'd0));
        end
        tick();
        checks++;
        if (obs !== exp_of(P_DEC, 2'd0)) begin
            fails++; $display("FAIL reset_idle: got %b expected %b", obs, exp_of(P_DEC, 2'd0));
        end
    endtask

    task automatic test_basic_packet();
        int ph_seq [7] = '{P_LFD, P_LD, P_LD, P_LD, P_LP, P_CPE, P_DEC};
        bit pv_seq [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int wen_cnt = 0;
        int rst_cnt = 0;
        empty   = 3'b111;
        data_in = 2'd1;
        for (int i = 0; i < 7; i++) begin
            pkt_valid = pv_seq[i];
            tick();
            data_in = 2'($urandom_range(0, 3));
            wen_cnt += int'(write_enb_reg);
            rst_cnt += int'(rst_int_reg);
            checks++;
            if (obs !== exp_of(ph_seq[i], 2'd1)) begin
                fails++; $display("FAIL basic_pkt cycle %0d: got %b expected %b", i, obs, exp_of(ph_seq[i], 2'd1));
            end
        end
        checks++;
        if (wen_cnt != 4) begin
            fails++; $display("FAIL basic_wen_count: got %0d expected 4", wen_cnt);
        end
        checks++;
        if (rst_cnt != 1) begin
            fails++; $display("FAIL basic_rst_int_count: got %0d expected 1", rst_cnt);
        end
    endtask

    task automatic test_wait_empty();
        int tail [4] = '{P_LD, P_LP, P_CPE, P_DEC};
        empty     = 3'b011;
        data_in   = 2'd2;
        pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== exp_of(P_WTE, 2'd2)) begin
                fails++; $display("FAIL wait_empty cycle %0d: got %b expected %b", i, obs, exp_of(P_WTE, 2'd2));
            end
        end
        empty = 3'b111;
        tick();
        checks++;
        if (obs !== exp_of(P_LFD, 2'd2)) begin
            fails++; $display("FAIL wait_to_lfd: got %b expected %b", obs, exp_of(P_LFD, 2'd2));
        end
        pkt_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_of(tail[i], 2'd2)) begin
                fails++; $display("FAIL wait_tail cycle %0d: got %b expected %b", i, obs, exp_of(tail[i], 2'd2));
            end
        end
    endtask

    // variant 0: resume payload, 1: low_pkt_valid, 2: parity_done
    task automatic test_fifo_full(input int variant);
        int ph;
        empty = 3'b111; data_in = 2'd0; pkt_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== exp_of(P_LD, 2'd0)) begin
            fails++; $display("FAIL full_v%0d_ld: got %b expected %b", variant, obs, exp_of(P_LD, 2'd0));
        end
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) fifo_full = 1'b0;
            checks++;
            if (obs !== exp_of(P_FULL, 2'd0)) begin
                fails++; $display("FAIL full_v%0d_full cycle %0d: got %b expected %b", variant, i, obs, exp_of(P_FULL, 2'd0));
            end
        end
        tick();
        checks++;
        if (obs !== exp_of(P_LAF, 2'd0)) begin
            fails++; $display("FAIL full_v%0d_laf: got %b expected %b", variant, obs, exp_of(P_LAF, 2'd0));
        end
        low_pkt_valid = (variant == 1);
        parity_done   = (variant == 2);
        tick();
        low_pkt_valid = 1'b0;
        parity_done   = 1'b0;
        pkt_valid     = 1'b0;
        ph = (variant == 0) ? P_LD : (variant == 1) ? P_LP : P_DEC;
        checks++;
        if (obs !== exp_of(ph, 2'd0)) begin
            fails++; $display("FAIL full_v%0d_after_laf: got %b expected %b", variant, obs, exp_of(ph, 2'd0));
        end
        while (ph != P_DEC) begin
            ph = (ph == P_LD) ? P_LP : (ph == P_LP) ? P_CPE : P_DEC;
            tick();
            checks++;
            if (obs !== exp_of(ph, 2'd0)) begin
                fails++; $display("FAIL full_v%0d_drain: got %b expected %b", variant, obs, exp_of(ph, 2'd0));
            end
        end
    endtask

    task automatic test_soft_reset();
        empty = 3'b111; data_in = 2'd0; pkt_valid = 1'b1;
        tick();
        tick();
        sreset = 3'b010;
        tick();
        sreset = 3'b000;
        checks++;
        if (obs !== exp_of(P_LD, 2'd0)) begin
            fails++; $display("FAIL soft_other_port: got %b expected %b", obs, exp_of(P_LD, 2'd0));
        end
        fifo_full = 1'b1;
        tick();
        checks++;
        if (obs !== exp_of(P_FULL, 2'd0)) begin
            fails++; $display("FAIL soft_enter_full: got %b expected %b", obs, exp_of(P_FULL, 2'd0));
        end
        sreset    = 3'b001;
        pkt_valid = 1'b0;
        tick();
        sreset    = 3'b000;
        fifo_full = 1'b0;
        checks++;
        if (obs !== exp_of(P_DEC, 2'd0)) begin
            fails++; $display("FAIL soft_selected_port: got %b expected %b", obs, exp_of(P_DEC, 2'd0));
        end
    endtask

    task automatic test_invalid_and_reset();
        empty = 3'b111; pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== exp_of(P_DEC, 2'd0)) begin
                fails++; $display("FAIL invalid_addr cycle %0d: got %b expected %b", i, obs, exp_of(P_DEC, 2'd0));
            end
        end
        data_in = 2'd2;
        tick();
        checks++;
        if (obs !== exp_of(P_LFD, 2'd2)) begin
            fails++; $display("FAIL hdr_latency: got %b expected %b", obs, exp_of(P_LFD, 2'd2));
        end
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        pkt_valid = 1'b0;
        checks++;
        if (obs !== exp_of(P_DEC, 2'd0)) begin
            fails++; $display("FAIL reset_mid_packet: got %b expected %b", obs, exp_of(P_DEC, 2'd0));
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        m_ph = P_DEC; m_addr = 2'd0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom_range(0, 3));
            fifo_full     = ($urandom_range(0, 3) == 0);
            empty         = 3'($urandom_range(0, 7));
            sreset[0]     = ($urandom_range(0, 39) == 0);
            sreset[1]     = ($urandom_range(0, 39) == 0);
            sreset[2]     = ($urandom_range(0, 39) == 0);
            parity_done   = ($urandom_range(0, 5) == 0);
            low_pkt_valid = ($urandom_range(0, 5) == 0);
            model_step();
            tick();
            checks++;
            if (obs !== exp_of(m_ph, m_addr)) begin
                fails++; $display("FAIL random cycle %0d: got %b expected %b", i, obs, exp_of(m_ph, m_addr));
            end
        end
        reset = 1'b0; sreset = 3'b000;
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_wait_empty();
        test_fifo_full(0);
        test_fifo_full(1);
        test_fifo_full(2);
        test_soft_reset();
        test_invalid_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
